// File: rtl/if_stage.sv
// Instruction fetch stage: issues word fetches to instruction memory and hands
// fetched instructions to IF/ID through a one-entry output buffer plus one pending slot.
module if_stage #(
    parameter logic [31:0] RESET_PC = 32'h00000060
) (
    input  logic        clk,
    input  logic        rst,
    output logic        imem_read,
    output logic [31:0] imem_address,
    input  logic        imem_resp,
    input  logic [31:0] imem_rdata,
    input  logic        stall,
    input  logic        redirect,
    input  logic [31:0] redirect_pc,
    output logic        instr_valid,
    output logic [31:0] pc_out,
    output logic [31:0] instr_out
);

    typedef enum logic [1:0] {
        S_FETCH   = 2'd0,
        S_HOLD    = 2'd1,
        S_DISCARD = 2'd2
    } state_t;

    state_t      r_state;
    logic [31:0] r_pc;
    logic [31:0] r_discard_addr;
    logic [31:0] r_pend_pc;
    logic [31:0] r_pend_instr;
    logic        r_valid;
    logic [31:0] r_pc_q;
    logic [31:0] r_instr_q;

    logic        w_consume;
    logic        w_free;
    logic        w_load;
    logic [31:0] w_load_pc;
    logic [31:0] w_load_instr;
    logic [31:0] w_pc_inc;
    logic [31:0] w_pend_inc;

    assign w_consume  = r_valid & ~stall;
    assign w_free     = ~r_valid | w_consume;
    assign w_pc_inc   = r_pc + 32'd4;
    assign w_pend_inc = r_pend_pc + 32'd4;

    assign instr_valid = r_valid;
    assign pc_out      = r_pc_q;
    assign instr_out   = r_instr_q;

    // Memory request: a request stays up (at a stable address) until its response arrives.
    always_comb begin
        imem_read    = 1'b0;
        imem_address = r_pc;
        case (r_state)
            S_FETCH: begin
                imem_read    = rst;
                imem_address = r_pc;
            end
            S_HOLD: begin
                imem_read    = 1'b0;
                imem_address = r_pc;
            end
            S_DISCARD: begin
                imem_read    = rst;
                imem_address = r_discard_addr;
            end
            default: begin
                imem_read    = 1'b0;
                imem_address = r_pc;
            end
        endcase
    end

    // Output buffer load source: fresh response in FETCH, pending slot in HOLD.
    always_comb begin
        w_load       = 1'b0;
        w_load_pc    = r_pc;
        w_load_instr = imem_rdata;
        case (r_state)
            S_FETCH: begin
                w_load       = imem_resp & ~redirect & w_free;
                w_load_pc    = r_pc;
                w_load_instr = imem_rdata;
            end
            S_HOLD: begin
                w_load       = w_consume;
                w_load_pc    = r_pend_pc;
                w_load_instr = r_pend_instr;
            end
            S_DISCARD: begin
                w_load       = 1'b0;
                w_load_pc    = r_pc;
                w_load_instr = imem_rdata;
            end
            default: begin
                w_load       = 1'b0;
                w_load_pc    = r_pc;
                w_load_instr = imem_rdata;
            end
        endcase
    end

    // Fetch FSM, PC, pending slot and output buffer.
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state        <= S_FETCH;
            r_pc           <= RESET_PC;
            r_discard_addr <= 32'd0;
            r_pend_pc      <= 32'd0;
            r_pend_instr   <= 32'd0;
            r_valid        <= 1'b0;
            r_pc_q         <= 32'd0;
            r_instr_q      <= 32'd0;
        end else begin
            case (r_state)
                S_FETCH: begin
                    if (imem_resp && !redirect) begin
                        if (w_free) begin
                            r_pc <= w_pc_inc;
                        end else begin
                            r_pend_pc    <= r_pc;
                            r_pend_instr <= imem_rdata;
                            r_state      <= S_HOLD;
                        end
                    end else if (imem_resp && redirect) begin
                        r_pc <= redirect_pc;
                    end else if (redirect) begin
                        r_discard_addr <= r_pc;
                        r_pc           <= redirect_pc;
                        r_state        <= S_DISCARD;
                    end else begin
                        r_pc <= r_pc;
                    end
                end
                S_HOLD: begin
                    if (redirect) begin
                        r_pc    <= redirect_pc;
                        r_state <= S_FETCH;
                    end else if (w_consume) begin
                        r_pc    <= w_pend_inc;
                        r_state <= S_FETCH;
                    end else begin
                        r_state <= S_HOLD;
                    end
                end
                S_DISCARD: begin
                    if (redirect) begin
                        r_pc <= redirect_pc;
                    end else begin
                        r_pc <= r_pc;
                    end
                    if (imem_resp) begin
                        r_state <= S_FETCH;
                    end else begin
                        r_state <= S_DISCARD;
                    end
                end
                default: begin
                    r_state <= S_FETCH;
                end
            endcase

            // A redirect flushes the buffer even if something would load this cycle.
            if (redirect) begin
                r_valid <= 1'b0;
            end else if (w_load) begin
                r_valid   <= 1'b1;
                r_pc_q    <= w_load_pc;
                r_instr_q <= w_load_instr;
            end else if (w_consume) begin
                r_valid <= 1'b0;
            end else begin
                r_valid <= r_valid;
            end
        end
    end

endmodule

// File: tb/tb_if_stage.sv
// Self-checking bench for if_stage: directed scenarios plus a randomised
// stall/latency stream checked against a program-order scoreboard.
module tb_if_stage;

    logic        clk;
    logic        rst;
    logic        imem_read;
    logic [31:0] imem_address;
    logic        imem_resp;
    logic [31:0] imem_rdata;
    logic        stall;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic        instr_valid;
    logic [31:0] pc_out;
    logic [31:0] instr_out;

    int total;
    int bad;
    logic [31:0] exp_pc[$];
    logic [31:0] exp_ins[$];

    if_stage #(.RESET_PC(32'h00000060)) dut (
        .clk(clk), .rst(rst),
        .imem_read(imem_read), .imem_address(imem_address),
        .imem_resp(imem_resp), .imem_rdata(imem_rdata),
        .stall(stall), .redirect(redirect), .redirect_pc(redirect_pc),
        .instr_valid(instr_valid), .pc_out(pc_out), .instr_out(instr_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return {a[15:0], a[31:16]} ^ 32'h5A3C96E1;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b0; imem_resp = 1'b0; redirect = 1'b0; stall = 1'b0;
        redirect_pc = 32'd0; imem_rdata = 32'd0;
        step(); step();
        rst = 1'b1;
        #1;
        exp_pc.delete(); exp_ins.delete();
    endtask

    task automatic test_reset();
        rst = 1'b0; stall = 1'b0; redirect = 1'b0; redirect_pc = 32'd0;
        imem_resp = 1'b1; imem_rdata = 32'hDEADBEEF;
        #1;
        total++;
        if (imem_read !== 1'b0) begin bad++; $display("FAIL reset_read_gated got=%b want=0", imem_read); end
        step(); step();
        total++;
        if (instr_valid !== 1'b0 || pc_out !== 32'd0 || instr_out !== 32'd0) begin
            bad++; $display("FAIL reset_buffer got v=%b pc=%h ins=%h want 0/0/0", instr_valid, pc_out, instr_out);
        end
        total++;
        if (imem_read !== 1'b0) begin bad++; $display("FAIL reset_read_hold got=%b want=0", imem_read); end
        imem_resp = 1'b0; rst = 1'b1;
        #1;
        total++;
        if (imem_read !== 1'b1 || imem_address !== 32'h60) begin
            bad++; $display("FAIL reset_first_req got rd=%b a=%h want 1/00000060", imem_read, imem_address);
        end
    endtask

    task automatic test_sequential();
        logic [31:0] addr;
        for (int i = 0; i < 3; i++) begin
            addr = 32'h60 + 32'(4 * i);
            total++;
            if (imem_read !== 1'b1 || imem_address !== addr) begin
                bad++; $display("FAIL seq_req got rd=%b a=%h want 1/%h", imem_read, imem_address, addr);
            end
            imem_resp = 1'b1; imem_rdata = mem_word(addr);
            exp_pc.push_back(addr); exp_ins.push_back(mem_word(addr));
            step();
            total++;
            if (instr_valid !== 1'b1 || pc_out !== exp_pc[0] || instr_out !== exp_ins[0]) begin
                bad++; $display("FAIL seq_out got v=%b pc=%h ins=%h want 1/%h/%h", instr_valid, pc_out, instr_out, exp_pc[0], exp_ins[0]);
            end
            void'(exp_pc.pop_front()); void'(exp_ins.pop_front());
        end
        imem_resp = 1'b0;
        step();
        total++;
        if (instr_valid !== 1'b0) begin bad++; $display("FAIL seq_drain got v=%b want 0", instr_valid); end
    endtask

    task automatic test_stall_hold();
        do_reset();
        imem_resp = 1'b1; imem_rdata = mem_word(32'h60);
        exp_pc.push_back(32'h60); exp_ins.push_back(mem_word(32'h60));
        step();
        total++;
        if (imem_read !== 1'b1 || imem_address !== 32'h64) begin
            bad++; $display("FAIL hold_req64 got rd=%b a=%h want 1/00000064", imem_read, imem_address);
        end
        stall = 1'b1; imem_rdata = mem_word(32'h64);
        exp_pc.push_back(32'h64); exp_ins.push_back(mem_word(32'h64));
        step();
        imem_resp = 1'b0;
        for (int k = 0; k < 2; k++) begin
            total++;
            if (imem_read !== 1'b0 || instr_valid !== 1'b1 || pc_out !== 32'h60) begin
                bad++; $display("FAIL hold_state got rd=%b v=%b pc=%h want 0/1/00000060", imem_read, instr_valid, pc_out);
            end
            step();
        end
        stall = 1'b0;
        total++;
        if (instr_valid !== 1'b1 || pc_out !== exp_pc[0] || instr_out !== exp_ins[0]) begin
            bad++; $display("FAIL hold_first got pc=%h ins=%h want %h/%h", pc_out, instr_out, exp_pc[0], exp_ins[0]);
        end
        void'(exp_pc.pop_front()); void'(exp_ins.pop_front());
        step();
        total++;
        if (instr_valid !== 1'b1 || pc_out !== exp_pc[0] || instr_out !== exp_ins[0]) begin
            bad++; $display("FAIL hold_pending got v=%b pc=%h ins=%h want 1/%h/%h", instr_valid, pc_out, instr_out, exp_pc[0], exp_ins[0]);
        end
        void'(exp_pc.pop_front()); void'(exp_ins.pop_front());
        total++;
        if (imem_read !== 1'b1 || imem_address !== 32'h68) begin
            bad++; $display("FAIL hold_next_req got rd=%b a=%h want 1/00000068", imem_read, imem_address);
        end
        step();
        total++;
        if (instr_valid !== 1'b0) begin bad++; $display("FAIL hold_drain got v=%b want 0", instr_valid); end
    endtask

    task automatic test_redirect_outstanding();
        do_reset();
        redirect = 1'b1; redirect_pc = 32'h200;
        step();
        redirect = 1'b0;
        total++;
        if (imem_read !== 1'b1 || imem_address !== 32'h60 || instr_valid !== 1'b0) begin
            bad++; $display("FAIL disc_hold_addr got rd=%b a=%h v=%b want 1/00000060/0", imem_read, imem_address, instr_valid);
        end
        step();
        redirect = 1'b1; redirect_pc = 32'h300;
        step();
        redirect = 1'b0;
        total++;
        if (imem_address !== 32'h60) begin bad++; $display("FAIL disc_re_redirect got a=%h want 00000060", imem_address); end
        imem_resp = 1'b1; imem_rdata = mem_word(32'h60);
        step();
        imem_resp = 1'b0;
        total++;
        if (instr_valid !== 1'b0 || imem_read !== 1'b1 || imem_address !== 32'h300) begin
            bad++; $display("FAIL disc_drop got v=%b rd=%b a=%h want 0/1/00000300", instr_valid, imem_read, imem_address);
        end
        imem_resp = 1'b1; imem_rdata = mem_word(32'h300);
        exp_pc.push_back(32'h300); exp_ins.push_back(mem_word(32'h300));
        step();
        imem_resp = 1'b0;
        total++;
        if (instr_valid !== 1'b1 || pc_out !== exp_pc[0] || instr_out !== exp_ins[0]) begin
            bad++; $display("FAIL disc_refetch got v=%b pc=%h ins=%h want 1/%h/%h", instr_valid, pc_out, instr_out, exp_pc[0], exp_ins[0]);
        end
        void'(exp_pc.pop_front()); void'(exp_ins.pop_front());
        step();
    endtask

    task automatic test_redirect_with_resp();
        imem_resp = 1'b1; imem_rdata = mem_word(32'h304);
        step();
        total++;
        if (instr_valid !== 1'b1 || pc_out !== 32'h304) begin
            bad++; $display("FAIL rr_setup got v=%b pc=%h want 1/00000304", instr_valid, pc_out);
        end
        stall = 1'b1; imem_rdata = mem_word(32'h308); redirect = 1'b1; redirect_pc = 32'h400;
        step();
        imem_resp = 1'b0; redirect = 1'b0; stall = 1'b0;
        total++;
        if (instr_valid !== 1'b0 || imem_read !== 1'b1 || imem_address !== 32'h400) begin
            bad++; $display("FAIL rr_flush got v=%b rd=%b a=%h want 0/1/00000400", instr_valid, imem_read, imem_address);
        end
        imem_resp = 1'b1; imem_rdata = mem_word(32'h400);
        exp_pc.push_back(32'h400); exp_ins.push_back(mem_word(32'h400));
        step();
        total++;
        if (instr_valid !== 1'b1 || pc_out !== exp_pc[0] || instr_out !== exp_ins[0]) begin
            bad++; $display("FAIL rr_target got v=%b pc=%h want 1/%h", instr_valid, pc_out, exp_pc[0]);
        end
        void'(exp_pc.pop_front()); void'(exp_ins.pop_front());
        stall = 1'b1; imem_rdata = mem_word(32'h404);
        step();
        imem_resp = 1'b0;
        total++;
        if (imem_read !== 1'b0) begin bad++; $display("FAIL rr_hold_entry got rd=%b want 0", imem_read); end
        redirect = 1'b1; redirect_pc = 32'h500; stall = 1'b0;
        step();
        redirect = 1'b0;
        total++;
        if (instr_valid !== 1'b0 || imem_read !== 1'b1 || imem_address !== 32'h500) begin
            bad++; $display("FAIL rr_hold_redirect got v=%b rd=%b a=%h want 0/1/00000500", instr_valid, imem_read, imem_address);
        end
        imem_resp = 1'b1; imem_rdata = mem_word(32'h500);
        step();
        imem_resp = 1'b0;
        total++;
        if (instr_valid !== 1'b1 || pc_out !== 32'h500 || instr_out !== mem_word(32'h500)) begin
            bad++; $display("FAIL rr_after_hold got v=%b pc=%h want 1/00000500", instr_valid, pc_out);
        end
        step();
    endtask

    task automatic test_reset_in_discard();
        do_reset();
        redirect = 1'b1; redirect_pc = 32'h700;
        step();
        redirect = 1'b0;
        rst = 1'b0; imem_resp = 1'b1; imem_rdata = 32'hCAFEF00D;
        #1;
        total++;
        if (imem_read !== 1'b0) begin bad++; $display("FAIL rst_disc_gate got rd=%b want 0", imem_read); end
        step(); step();
        imem_resp = 1'b0; rst = 1'b1;
        #1;
        total++;
        if (imem_read !== 1'b1 || imem_address !== 32'h60 || instr_valid !== 1'b0) begin
            bad++; $display("FAIL rst_disc_restart got rd=%b a=%h v=%b want 1/00000060/0", imem_read, imem_address, instr_valid);
        end
    endtask

    task automatic test_wrap();
        do_reset();
        imem_resp = 1'b1; imem_rdata = mem_word(32'h60); redirect = 1'b1; redirect_pc = 32'hFFFFFFFC;
        step();
        redirect = 1'b0;
        imem_rdata = mem_word(32'hFFFFFFFC);
        total++;
        if (imem_address !== 32'hFFFFFFFC || instr_valid !== 1'b0) begin
            bad++; $display("FAIL wrap_setup got a=%h v=%b want fffffffc/0", imem_address, instr_valid);
        end
        step();
        imem_resp = 1'b0;
        total++;
        if (imem_address !== 32'h0 || instr_valid !== 1'b1 || pc_out !== 32'hFFFFFFFC) begin
            bad++; $display("FAIL wrap got a=%h v=%b pc=%h want 00000000/1/fffffffc", imem_address, instr_valid, pc_out);
        end
        step();
    endtask

    task automatic test_back_to_back();
        logic go;
        do_reset();
        for (int c = 0; c < 400; c++) begin
            stall = ($urandom_range(0, 3) == 0);
            go = imem_read && ($urandom_range(0, 2) != 0);
            imem_resp = go;
            if (go) begin
                imem_rdata = mem_word(imem_address);
                exp_pc.push_back(imem_address); exp_ins.push_back(mem_word(imem_address));
            end
            if (instr_valid && !stall) begin
                total++;
                if (exp_pc.size() == 0) begin
                    bad++; $display("FAIL b2b_extra got pc=%h want no instruction", pc_out);
                end else begin
                    if (pc_out !== exp_pc[0] || instr_out !== exp_ins[0]) begin
                        bad++; $display("FAIL b2b_order got pc=%h ins=%h want %h/%h", pc_out, instr_out, exp_pc[0], exp_ins[0]);
                    end
                    void'(exp_pc.pop_front()); void'(exp_ins.pop_front());
                end
            end
            step();
        end
        imem_resp = 1'b0; stall = 1'b0;
        for (int c = 0; c < 4; c++) begin
            if (instr_valid) begin
                total++;
                if (exp_pc.size() == 0 || pc_out !== exp_pc[0]) begin
                    bad++; $display("FAIL b2b_tail got pc=%h want queued pc", pc_out);
                end
                if (exp_pc.size() != 0) begin
                    void'(exp_pc.pop_front()); void'(exp_ins.pop_front());
                end
            end
            step();
        end
        total++;
        if (exp_pc.size() != 0) begin
            bad++; $display("FAIL b2b_lost got remaining=%0d want 0", exp_pc.size());
        end
    endtask

    initial begin
        total = 0;
        bad = 0;
        test_reset();
        test_sequential();
        test_stall_hold();
        test_redirect_outstanding();
        test_redirect_with_resp();
        test_reset_in_discard();
        test_wrap();
        test_back_to_back();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout got no completion want finish");
        $fatal(1);
    end

endmodule

// File: doc/if_stage.md
IF_STAGE -- requirements
Module: if_stage

Interface
REQ-001 Parameter RESET_PC, default 32'h00000060: PC value loaded on reset.
REQ-002 clk  input  1  sole clock; all state updates on rising edge.
REQ-003 rst  input  1  reset; synchronous, active-low (0 = reset).
REQ-004 imem_read  output  1  instruction memory read request.
REQ-005 imem_address  output  32  word-aligned fetch address; stable while imem_read=1 until imem_resp.
REQ-006 imem_resp  input  1  memory response strobe; imem_rdata valid in the same cycle.
REQ-007 imem_rdata  input  32  fetched instruction word.
REQ-008 stall  input  1  downstream (IF/ID) cannot accept this cycle.
REQ-009 redirect  input  1  taken branch/jump; flush and refetch.
REQ-010 redirect_pc  input  32  target PC; sampled only when redirect=1.
REQ-011 instr_valid  output  1  output buffer holds an instruction for IF/ID.
REQ-012 pc_out  output  32  PC of the buffered instruction.
REQ-013 instr_out  output  32  buffered instruction word.

Function
REQ-014 State: pc (32 b), state in {FETCH, HOLD, DISCARD}, discard_addr, pending pc/instr (HOLD only), output buffer (valid_q, pc_q, instr_q).
REQ-015 Consume event = valid_q & ~stall; the buffer counts as free when valid_q=0 or a consume event occurs.
REQ-016 FETCH: imem_read=1, imem_address=pc.
REQ-017 FETCH, imem_resp=1, redirect=0, buffer free: buffer <= {1, pc, imem_rdata}; pc <= pc+4; stay FETCH (back-to-back fetch, one instruction per response).
REQ-018 FETCH, imem_resp=1, redirect=0, buffer not free: pending <= {pc, imem_rdata}; go HOLD.
REQ-019 FETCH, imem_resp=1, redirect=1: drop the response; pc <= redirect_pc; stay FETCH.
REQ-020 FETCH, imem_resp=0, redirect=1: discard_addr <= pc; pc <= redirect_pc; go DISCARD (an outstanding request is never abandoned).
REQ-021 HOLD: imem_read=0; on a consume event, buffer <= pending, pc <= pending pc+4, go FETCH.
REQ-022 HOLD with redirect=1: drop pending; pc <= redirect_pc; go FETCH (redirect wins over consume).
REQ-023 DISCARD: imem_read=1, imem_address=discard_addr; on imem_resp, drop data and go FETCH.
REQ-024 DISCARD with redirect=1: pc <= latest redirect_pc; if imem_resp is also 1 go FETCH, else stay DISCARD.
REQ-025 redirect=1 in any state: valid_q <= 0 next cycle (flush), overriding any buffer load that cycle.
REQ-026 If there is no consume event and no redirect, the buffer holds its value and instr_valid stays 1.
REQ-027 stall never blocks an outstanding request; it only blocks buffer drain.
REQ-028 pc+4 wraps modulo 2^32 (32'hFFFFFFFC -> 32'h00000000); no overflow flag.
REQ-029 Latency: imem_resp at cycle N, with the buffer free -> instr_valid=1 with that instruction at cycle N+1.
REQ-030 Instructions leave in program order; none is duplicated or lost except on a redirect flush.

Reset
REQ-031 rst=0 at an edge: state=FETCH, pc=RESET_PC, valid_q=0, pc_q=0, instr_q=0, pending and discard_addr cleared.
REQ-032 While rst=0: imem_read=0 (combinationally gated) and imem_resp is ignored.
REQ-033 A reset during HOLD or DISCARD abandons all in-flight state; the first request after reset is to RESET_PC.

Verification
REQ-034 Release reset, 1-cycle memory, stall=0 -> addresses 0x60, 0x64, 0x68 on consecutive requests; instr_valid=1 with pc_out=0x60 one cycle after the first resp.
REQ-035 Buffer full, stall=1, resp for 0x64 -> HOLD, imem_read=0; drop stall -> pc_out=0x64 the next cycle, then request 0x68.
REQ-036 Redirect to 0x200 while the 0x68 request is outstanding -> imem_address stays 0x68 until resp, data dropped, next request 0x200, no instr_valid for 0x68.
REQ-037 redirect and imem_resp in the same FETCH cycle -> instr_valid=0 next cycle, next request to redirect_pc.
REQ-038 rst=0 asserted in DISCARD mid-request -> imem_read=0 during reset; after release the first address is 0x60 and instr_valid=0.
REQ-039 pc=32'hFFFFFFFC, resp accepted -> next imem_address=32'h00000000.
